// File: rtl/alu_issue_sequencer.sv
// EX-stage issue sequencer: passes single-cycle integer ops straight through and
// holds the pipeline for the fixed latency of integer mult/div and all FPU ops.
module alu_issue_sequencer #(
    parameter int CTRL_W    = 4,
    parameter int CNT_W     = 5,
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 16,
    parameter int FADD_LAT  = 3,
    parameter int FMUL_LAT  = 4,
    parameter int FDIV_LAT  = 12,
    parameter int FMISC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic              alu_select,
    input  logic [CTRL_W-1:0] control,
    input  logic              flush,
    output logic              issue_ready,
    output logic              int_start,
    output logic              fpu_start,
    output logic [CTRL_W-1:0] unit_ctrl,
    output logic              stall,
    output logic              done,
    output logic              busy_fpu,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              sel_q;

    logic              accept;
    logic              multi;
    logic [CNT_W-1:0]  lat_m1;

    // Latency minus one, so the counter hits 1 on the last RUN cycle.
    function automatic logic [CNT_W-1:0] op_lat_m1(input logic sel, input logic [CTRL_W-1:0] c);
        int lat;
        if (!sel) begin
            lat = (c == CTRL_W'(11)) ? DIV_LAT : MUL_LAT;
        end else begin
            case (c)
                CTRL_W'(0), CTRL_W'(1): lat = FADD_LAT;
                CTRL_W'(2):             lat = FMUL_LAT;
                CTRL_W'(4):             lat = FDIV_LAT;
                default:                lat = FMISC_LAT;
            endcase
        end
        return CNT_W'(lat - 1);
    endfunction

    assign issue_ready = (state_q != RUN);
    assign accept      = issue_valid & issue_ready & ~flush;
    assign multi       = alu_select | (control == CTRL_W'(10)) | (control == CTRL_W'(11));
    assign lat_m1      = op_lat_m1(alu_select, control);

    assign int_start = accept & ~alu_select;
    assign fpu_start = accept & alu_select;
    assign stall     = (accept & multi) | (state_q == RUN);
    assign done      = (state_q == DONE) & ~flush;
    assign busy_fpu  = (state_q != IDLE) & sel_q;
    assign unit_ctrl = (state_q == RUN) ? ctrl_q : (accept ? control : '0);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            sel_q   <= 1'b0;
        end else if (flush) begin
            // Squash; acceptance is already blocked this cycle.
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= DONE;
                end
                default: begin
                    if (accept && multi) begin
                        state_q <= RUN;
                        cnt_q   <= lat_m1;
                        ctrl_q  <= control;
                        sel_q   <= alu_select;
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: directed scenarios then random traffic, checked
// every cycle against a model that tracks the in-flight op by its absolute end cycle.
module tb_alu_issue_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid = 1'b0;
  logic       alu_select = 1'b0;
  logic [3:0] control = 4'd0;
  logic       flush = 1'b0;
  logic       issue_ready, int_start, fpu_start, stall, done, busy_fpu;
  logic [3:0] unit_ctrl;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // model: one in-flight op finishing (done) at absolute cycle m_end
  bit         m_act = 0;
  int         m_end = 0;
  logic [3:0] m_ctrl = 0;
  logic       m_sel = 0;
  int         cyc = 0;

  alu_issue_sequencer dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .alu_select(alu_select),
    .control(control), .flush(flush), .issue_ready(issue_ready), .int_start(int_start),
    .fpu_start(fpu_start), .unit_ctrl(unit_ctrl), .stall(stall), .done(done),
    .busy_fpu(busy_fpu), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int ref_lat(input logic s, input logic [3:0] c);
    if (!s) return (c == 4'd10) ? 4 : 16;
    case (c)
      4'd0, 4'd1: return 3;
      4'd2:       return 4;
      4'd4:       return 12;
      default:    return 2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_ready", 32'(issue_ready), 1);
    chk("rst_int_start", 32'(int_start), 0);
    chk("rst_fpu_start", 32'(fpu_start), 0);
    chk("rst_unit_ctrl", 32'(unit_ctrl), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy_fpu", 32'(busy_fpu), 0);
  endtask

  // Called at posedge+1; checks at negedge, advances model at next posedge.
  task automatic step(input logic v, input logic s, input logic [3:0] c, input logic f);
    bit running, dcyc, multi, acc;
    issue_valid = v; alu_select = s; control = c; flush = f;
    @(negedge clk);
    running = m_act && (cyc < m_end);
    dcyc    = m_act && (cyc == m_end);
    multi   = s || (c == 4'd10) || (c == 4'd11);
    acc     = v && !running && !f;
    chk("issue_ready", 32'(issue_ready), 32'(!running));
    chk("int_start", 32'(int_start), 32'(acc && !s));
    chk("fpu_start", 32'(fpu_start), 32'(acc && s));
    chk("unit_ctrl", 32'(unit_ctrl), running ? 32'(m_ctrl) : (acc ? 32'(c) : 0));
    chk("stall", 32'(stall), 32'((acc && multi) || running));
    chk("done", 32'(done), 32'(dcyc && !f));
    chk("busy_fpu", 32'(busy_fpu), (running || dcyc) ? 32'(m_sel) : 0);
    @(posedge clk);
    if (m_act && (f || dcyc)) m_act = 0;
    if (acc && multi) begin
      m_act  = 1;
      m_end  = cyc + ref_lat(s, c);
      m_ctrl = c;
      m_sel  = s;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    // clock/reset
    #1 chk_reset();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // single-cycle int add
    step(1'b1, 1'b0, 4'd0, 1'b0);
    idle(2);
    // int mult, latency 4
    step(1'b1, 1'b0, 4'd10, 1'b0);
    idle(5);
    // FPU divf with issue attempts during RUN
    step(1'b1, 1'b1, 4'd4, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd3, 1'b0);
    idle(8);
    // addf then back-to-back multf in the DONE cycle
    step(1'b1, 1'b1, 4'd0, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 4'd2, 1'b0);
    idle(5);
    // int div flushed at t+5
    step(1'b1, 1'b0, 4'd11, 1'b0);
    idle(4);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    idle(14);
    // flush landing exactly in the DONE cycle, with an issue attempt
    step(1'b1, 1'b1, 4'd7, 1'b0);
    idle(1);
    step(1'b1, 1'b1, 4'd2, 1'b1);
    idle(2);
    // unknown FPU code uses the misc latency
    step(1'b1, 1'b1, 4'd13, 1'b0);
    idle(3);
    // async reset mid-RUN of a divf
    step(1'b1, 1'b1, 4'd4, 1'b0);
    idle(4);
    rst_n = 1'b0;
    #1 chk_reset();
    m_act = 0;
    @(posedge clk); #1;
    chk_reset();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'd5, 1'b0);
    idle(2);

    // random traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), $urandom_range(0, 24) == 0);
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
